// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding and opcode width.
// Combinational constants only; no latency or flow control.
package alu_pkg;

  localparam int AluOpWidth = 4;

  typedef enum logic [AluOpWidth-1:0] {
    ADD  = 4'h0,
    SUB  = 4'h1,
    XOR  = 4'h2,
    OR   = 4'h3,
    AND  = 4'h4,
    SLL  = 4'h5,
    SRL  = 4'h6,
    SRA  = 4'h7,
    SLT  = 4'h8,
    SLTU = 4'h9,
    EQ   = 4'hA,
    NE   = 4'hB,
    LT   = 4'hC,
    GE   = 4'hD,
    LTU  = 4'hE,
    GEU  = 4'hF
  } alu_op_e;

endpackage

// File: rtl/alu.sv
// Combinational ALU, zero latency, no flow control of its own.
// Shift amounts come from src2[5:0]; compares return 1/0 zero-extended.
module alu
  import alu_pkg::*;
#(
  parameter int DataWidth = 32
) (
  input  logic [DataWidth-1:0]  src1,
  input  logic [DataWidth-1:0]  src2,
  input  logic [AluOpWidth-1:0] op,
  output logic [DataWidth-1:0]  result
);

  logic [5:0] shamt;
  logic       cmp;

  assign shamt = src2[5:0];

  always_comb begin
    result = '0;
    cmp    = 1'b0;
    case (alu_op_e'(op))
      ADD:  result = src1 + src2;
      SUB:  result = src1 - src2;
      XOR:  result = src1 ^ src2;
      OR:   result = src1 | src2;
      AND:  result = src1 & src2;
      SLL:  result = src1 << shamt;
      SRL:  result = src1 >> shamt;
      SRA:  result = $signed(src1) >>> shamt;
      SLT:  cmp = $signed(src1) < $signed(src2);
      SLTU: cmp = src1 < src2;
      EQ:   cmp = src1 == src2;
      NE:   cmp = src1 != src2;
      LT:   cmp = $signed(src1) < $signed(src2);
      GE:   cmp = $signed(src1) >= $signed(src2);
      LTU:  cmp = src1 < src2;
      GEU:  cmp = src1 >= src2;
      default: result = '0;
    endcase
    if (op >= 4'h8) result = {{(DataWidth-1){1'b0}}, cmp};
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant starting the search at ptr, wrapping modulo NumReq.
// Combinational, zero latency; grant is zero when no request is present.
module rr_arbiter #(
  parameter  int NumReq   = 2,
  localparam int PtrWidth = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic [NumReq-1:0]   req,
  input  logic [PtrWidth-1:0] ptr,
  output logic [NumReq-1:0]   grant
);

  logic [NumReq-1:0] mask;
  logic [NumReq-1:0] pick;

  // Prefer requesters at or above ptr; fall back to the full set to wrap.
  always_comb begin
    for (int k = 0; k < NumReq; k++) mask[k] = (k >= int'(ptr));
    pick  = (|(req & mask)) ? (req & mask) : req;
    grant = pick & (~pick + NumReq'(1));
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU among NumReq requesters; result in a 1-deep slot, 1-cycle latency.
// A full slot not being drained blocks all grants; ALU_ARBITER_PERF_EN adds grant/stall counters.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter  int NumReq    = 2,
  parameter  int DataWidth = 32,
  parameter  int TagWidth  = 4,
  localparam int IdWidth   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NumReq-1:0]            req_valid_i,
  output logic [NumReq-1:0]            req_ready_o,
  input  logic [NumReq*DataWidth-1:0]  req_src1_i,
  input  logic [NumReq*DataWidth-1:0]  req_src2_i,
  input  logic [NumReq*AluOpWidth-1:0] req_op_i,
  input  logic [NumReq*TagWidth-1:0]   req_tag_i,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic [DataWidth-1:0]         rsp_result_o,
  output logic [IdWidth-1:0]           rsp_id_o,
  output logic [TagWidth-1:0]          rsp_tag_o
`ifdef ALU_ARBITER_PERF_EN
  ,
  output logic [NumReq*32-1:0]         perf_grant_cnt_o,
  output logic [31:0]                  perf_stall_cnt_o
`endif
);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]            state;
  logic [IdWidth-1:0]    rr_ptr;
  logic [IdWidth-1:0]    gnt_idx;
  logic [NumReq-1:0]     gnt;
  logic                  can_accept;
  logic                  xfer;
  logic [DataWidth-1:0]  alu_src1;
  logic [DataWidth-1:0]  alu_src2;
  logic [DataWidth-1:0]  alu_res;
  logic [AluOpWidth-1:0] alu_op;
  logic [TagWidth-1:0]   gnt_tag;

  rr_arbiter #(.NumReq(NumReq)) u_rr (
    .req   (req_valid_i),
    .ptr   (rr_ptr),
    .grant (gnt)
  );

  assign rsp_valid_o = (state == FULL);
  assign can_accept  = (state == EMPTY) || (rsp_valid_o && rsp_ready_i);
  assign req_ready_o = (rst_i || !can_accept) ? '0 : gnt;
  assign xfer        = |req_ready_o;

  always_comb begin
    gnt_idx  = '0;
    alu_src1 = '0;
    alu_src2 = '0;
    alu_op   = '0;
    gnt_tag  = '0;
    for (int k = 0; k < NumReq; k++) begin
      if (gnt[k]) begin
        gnt_idx  = IdWidth'(k);
        alu_src1 = req_src1_i[k*DataWidth +: DataWidth];
        alu_src2 = req_src2_i[k*DataWidth +: DataWidth];
        alu_op   = req_op_i[k*AluOpWidth +: AluOpWidth];
        gnt_tag  = req_tag_i[k*TagWidth +: TagWidth];
      end
    end
  end

  alu #(.DataWidth(DataWidth)) u_alu (
    .src1   (alu_src1),
    .src2   (alu_src2),
    .op     (alu_op),
    .result (alu_res)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= EMPTY;
      rr_ptr       <= '0;
      rsp_result_o <= '0;
      rsp_id_o     <= '0;
      rsp_tag_o    <= '0;
    end else if (xfer) begin
      state        <= FULL;
      rsp_result_o <= alu_res;
      rsp_id_o     <= gnt_idx;
      rsp_tag_o    <= gnt_tag;
      rr_ptr       <= (gnt_idx == IdWidth'(NumReq - 1)) ? '0 : gnt_idx + IdWidth'(1);
    end else if (rsp_ready_i) begin
      // Drain without refill; payload registers keep their last values.
      state <= EMPTY;
    end
  end

`ifdef ALU_ARBITER_PERF_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_grant_cnt_o <= '0;
      perf_stall_cnt_o <= '0;
    end else begin
      for (int k = 0; k < NumReq; k++) begin
        if (req_ready_o[k]) perf_grant_cnt_o[k*32 +: 32] <= perf_grant_cnt_o[k*32 +: 32] + 32'd1;
      end
      if (|req_valid_i && !xfer) perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational ALU datapath (`alu`, ops 0x0–0xF) between NumReq requesters, e.g. the execute stage, branch-compare unit and address generator.
- Arbitration is round-robin. Each requester side uses a valid/ready handshake.
- The winner's operands go through the instantiated ALU. The result is captured in a single registered response slot with its own valid/ready handshake.
- Sits between the requesting units and the ALU. It is the only block driving ALU operands.

Parameters:
- NumReq, 2, number of requesters (1..8).
- DataWidth, 32, operand/result width passed to alu.
- TagWidth, 4, opaque requester tag returned with the result.

Ports:
- clk_i  input  1  clock. Everything is clocked on the rising edge.
- rst_i  input  1  reset. Synchronous, active-high.
- req_valid_i  input  NumReq  per-requester request valid.
- req_ready_o  output  NumReq  per-requester accept; one-hot or zero.
- req_src1_i  input  NumReq*DataWidth  flattened operand 1; requester k occupies bits [k*DataWidth +: DataWidth].
- req_src2_i  input  NumReq*DataWidth  flattened operand 2, same packing.
- req_op_i  input  NumReq*4  flattened alu_op, same packing.
- req_tag_i  input  NumReq*TagWidth  flattened tag, same packing.
- rsp_valid_o  output  1  response slot full.
- rsp_ready_i  input  1  consumer accepts the response.
- rsp_result_o  output  DataWidth  registered ALU result.
- rsp_id_o  output  IdWidth  index of the served requester; IdWidth = max(1, $clog2(NumReq)).
- rsp_tag_o  output  TagWidth  tag of the served request.

Behaviour:
- Reset values:
  - rsp_valid_o=0, rsp_result_o=0, rsp_id_o=0, rsp_tag_o=0.
  - Round-robin pointer rr_ptr=0. State=EMPTY.
  - req_ready_o=0 while rst_i is high.
- FSM has two states, EMPTY (slot free) and FULL (slot holds a result).
- can_accept = (state==EMPTY) | (rsp_valid_o & rsp_ready_i). A drain and a refill in the same cycle give full throughput of one op/cycle.
- Grant rule:
  - When can_accept is set, grant the first asserted req_valid_i searching from rr_ptr upward, wrapping modulo NumReq.
  - req_ready_o = one-hot grant; zero when !can_accept or no valid.
  - req_ready_o is combinational from req_valid_i, state and rsp_ready_i. It never depends on a requester's own ready.
- Handshake:
  - A transfer occurs on req_valid_i[k] & req_ready_o[k].
  - Requesters must hold valid and payload stable until accepted.
  - Valid must not be dropped without a transfer.
- On a transfer:
  - The ALU sees the granted src1, src2 and op.
  - Next cycle: rsp_result_o = ALU result, rsp_id_o = k, rsp_tag_o = tag, rsp_valid_o = 1, state = FULL.
  - rr_ptr = (k+1) mod NumReq. The wrap from NumReq-1 goes to 0.
- Latency is exactly 1 cycle from transfer to rsp_valid_o.
- If there is no transfer and rsp_ready_i is high in FULL: state goes to EMPTY and rsp_valid_o=0. Result, id and tag keep their last values.
- If FULL and !rsp_ready_i: all rsp_* outputs hold stable, req_ready_o=0, and rr_ptr is unchanged.
- rr_ptr changes only on a grant. A requester that stays valid is served within NumReq grants (no starvation).
- NumReq=1: the pointer is constant 0 and rsp_id_o=0.
- Reset asserted mid-operation discards any pending result and forces all reset values on the next edge. No response is emitted for the discarded result.
- Width and arithmetic follow alu exactly: shift amounts use src2[5:0], compares return 1/0 zero-extended.

Optional Feature:
- Macro: ALU_ARBITER_PERF_EN.
- When defined, the block adds two output ports:
  - perf_grant_cnt_o, NumReq*32: per-requester grant counters.
  - perf_stall_cnt_o, 32: cycles where any req_valid_i is high but no grant issues.
- Counters reset to 0 and wrap modulo 2^32.
- When undefined, the ports and counters are absent and all other behaviour is identical.

Decomposition:
- Shared package alu_pkg holds:
  - the alu_op_e enum: ADD=0x0, SUB=0x1, XOR=0x2, OR=0x3, AND=0x4, SLL=0x5, SRL=0x6, SRA=0x7, SLT=0x8, SLTU=0x9, EQ=0xA, NE=0xB, LT=0xC, GE=0xD, LTU=0xE, GEU=0xF;
  - the AluOpWidth=4 constant.
- The alu module is instantiated unchanged as the datapath.
- The round-robin grant logic is one natural sub-module, rr_arbiter (parameter NumReq; inputs req and ptr; output one-hot grant).

Test Plan:
- Reset then single op: req0 ADD 5+7, tag 3 → req_ready_o=01 the same cycle; next cycle rsp_valid_o=1, result 12, id 0, tag 3. rsp_ready_i=1 → next cycle rsp_valid_o=0.
- Contention: both requesters valid for 4 cycles, rsp_ready_i=1 → grants alternate 0,1,0,1; req0 SUB 3-5 returns 0xFFFFFFFE; req1 SLT(-1,1) returns 1.
- Backpressure: rsp_ready_i=0 for 3 cycles with a result held (SRA 0x80000000>>>4 = 0xF8000000) → outputs stable, req_ready_o=00, rr_ptr unchanged; release → request accepted the same cycle as the drain.
- Wrap and fairness with NumReq=3: req2 only, then all three valid → grant order 2,0,1,2.
- Reset mid-operation: assert rst_i while FULL → next cycle rsp_valid_o=0 and all outputs 0; the first grant after reset goes to req0.
- With ALU_ARBITER_PERF_EN defined, run the contention test → perf_grant_cnt 2/2 and perf_stall_cnt equals the number of backpressure cycles with a request pending.
